// File: rtl/numero_pkg.sv
// numero_pkg: shared types and constants for the numero sequencer
// Provides the FSM state type, BCD/code widths, digit index width and default digit count.
package numero_pkg;
  localparam int BCD_W = 4;
  localparam int CODE_W = 5;
  localparam int BCD_MAX = 9;
  localparam int IDX_W = 3;
  localparam int N_DIGITS_DEF = 4;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/numero_sequencer_digit_select.sv
// digit_select: picks digit idx_i out of the registered packed BCD word
// Ports: digits_i packed BCD copy, idx_i digit index, digit_o selected digit (0 if idx_i is out of range).
module digit_select
  import numero_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic [BCD_W*N_DIGITS-1:0] digits_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic [BCD_W-1:0]          digit_o
);
  always_comb begin
    digit_o = '0;
    for (int i = 0; i < N_DIGITS; i++)
      digit_o = (idx_i == IDX_W'(i)) ? digits_i[i*BCD_W +: BCD_W] : digit_o;
  end
endmodule

// File: rtl/numero_sequencer.sv
// numero_sequencer: drives a shared BCD-to-5-bit converter one digit per two-cycle slot and collects the codes
// Ports: clk/reset (sync, active-high); start/digits request; busy/done/erro/erro_idx/codes status and result;
// conv_abcd/conv_ready/conv_reset drive the external converter, conv_d/conv_invalid are its outputs.
module numero_sequencer
  import numero_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BCD_W*N_DIGITS-1:0]  digits,
  output logic                       busy,
  output logic                       done,
  output logic                       erro,
  output logic [IDX_W-1:0]           erro_idx,
  output logic [CODE_W*N_DIGITS-1:0] codes,
  output logic [BCD_W-1:0]           conv_abcd,
  output logic                       conv_ready,
  output logic                       conv_reset,
  input  logic [CODE_W-1:0]          conv_d,
  input  logic                       conv_invalid
);
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BCD_W*N_DIGITS-1:0]  digits_q, digits_d;
  logic [CODE_W*N_DIGITS-1:0] codes_q, codes_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       erro_q, erro_d;
  logic [IDX_W-1:0]           erro_idx_q, erro_idx_d;
  logic [BCD_W-1:0]           digit;
  logic                       accept, sample, hit, bad, last, drive;

  digit_select #(.N_DIGITS(N_DIGITS)) u_sel (
    .digits_i(digits_q),
    .idx_i   (idx_q),
    .digit_o (digit)
  );

  always_comb begin
    accept = state_q == S_IDLE && start;
    sample = state_q == S_SAMPLE;
    hit = sample && !conv_invalid;
    bad = sample && conv_invalid;
    last = idx_q == IDX_W'(N_DIGITS - 1);
    state_d = accept ? S_DRIVE :
              state_q == S_DRIVE ? S_SAMPLE :
              sample ? (conv_invalid ? S_ERR : last ? S_DONE : S_DRIVE) :
              (state_q == S_DONE || state_q == S_ERR) ? S_IDLE : state_q;
    digits_d = accept ? digits : digits_q;
    idx_d = accept ? '0 : hit ? idx_q + 1'b1 : idx_q;
    erro_d = accept ? 1'b0 : bad | erro_q;
    erro_idx_d = accept ? '0 : bad ? idx_q : erro_idx_q;
    codes_d = accept ? '0 : codes_q;
    for (int i = 0; i < N_DIGITS; i++)
      codes_d[i*CODE_W +: CODE_W] = (hit && idx_q == IDX_W'(i)) ? conv_d : codes_d[i*CODE_W +: CODE_W];
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE || state_d == S_ERR;
  end

  // Converter drive is decoded straight from reset so the converter is held in reset during the reset cycle itself.
  always_comb begin
    drive = (state_q == S_DRIVE || state_q == S_SAMPLE) && !reset;
    conv_abcd = drive ? digit : '0;
    conv_ready = drive;
    conv_reset = !drive;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      digits_q <= '0;
      codes_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      erro_q <= 1'b0;
      erro_idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      digits_q <= digits_d;
      codes_q <= codes_d;
      busy_q <= busy_d;
      done_q <= done_d;
      erro_q <= erro_d;
      erro_idx_q <= erro_idx_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign erro = erro_q;
  assign erro_idx = erro_idx_q;
  assign codes = codes_q;
endmodule

// File: tb/tb_numero_sequencer.sv
// tb_numero_sequencer: randomized self-checking bench with a stand-in converter and an arithmetic reference model
module tb_numero_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, busy, done, erro, conv_ready, conv_reset, conv_invalid;
  logic [15:0] digits;
  logic [2:0]  erro_idx;
  logic [19:0] codes;
  logic [3:0]  conv_abcd;
  logic [4:0]  conv_d;

  logic        start1, busy1, done1, erro1, conv_ready1, conv_reset1, conv_invalid1;
  logic [3:0]  digits1, conv_abcd1;
  logic [2:0]  erro_idx1;
  logic [4:0]  codes1, conv_d1;

  int pass_n = 0, total_n = 0;

  // Stand-in for the Numero converter: abacus-style table, garbage on invalid input.
  function automatic logic [4:0] conv(input logic [3:0] x);
    case (x)
      4'd0: return 5'b00000;
      4'd1: return 5'b10000;
      4'd2: return 5'b11000;
      4'd3: return 5'b11100;
      4'd4: return 5'b11110;
      4'd5: return 5'b11111;
      4'd6: return 5'b01111;
      4'd7: return 5'b00111;
      4'd8: return 5'b00011;
      4'd9: return 5'b00001;
      default: return 5'b11111;
    endcase
  endfunction

  assign conv_d = conv(conv_abcd);
  assign conv_invalid = conv_abcd > 4'd9;
  assign conv_d1 = conv(conv_abcd1);
  assign conv_invalid1 = conv_abcd1 > 4'd9;

  numero_sequencer #(.N_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .digits(digits), .busy(busy), .done(done), .erro(erro),
    .erro_idx(erro_idx), .codes(codes), .conv_abcd(conv_abcd), .conv_ready(conv_ready),
    .conv_reset(conv_reset), .conv_d(conv_d), .conv_invalid(conv_invalid)
  );

  numero_sequencer #(.N_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .digits(digits1), .busy(busy1), .done(done1), .erro(erro1),
    .erro_idx(erro_idx1), .codes(codes1), .conv_abcd(conv_abcd1), .conv_ready(conv_ready1),
    .conv_reset(conv_reset1), .conv_d(conv_d1), .conv_invalid(conv_invalid1)
  );

  // Code for digit v: v ones growing from d5 for 1..5, then shrinking from d5 for 6..9.
  function automatic logic [4:0] therm(input int v);
    logic [4:0] ones = 5'h1f;
    return v <= 5 ? ones << (5 - v) : ones >> (v - 5);
  endfunction

  // Whole-request outcome: codes of digits before the first bad one, error info and done cycle.
  task automatic model(input logic [31:0] d, input int n, output logic [39:0] c, output bit e,
                       output int ei, output int dc);
    c = '0; e = 0; ei = 0; dc = 2 * n + 1;
    for (int i = 0; i < n; i++) begin
      int v;
      v = int'(d[4*i +: 4]);
      if (v > 9) begin
        e = 1; ei = i; dc = 2 * i + 3;
        break;
      end
      c[5*i +: 5] = therm(v);
    end
  endtask

  task automatic go(input logic [15:0] d);
    @(negedge clk); start = 1'b1; digits = d;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic watch(input int maxc, output int done_at, output int busy_cnt, output bit saw1);
    done_at = -1; busy_cnt = 0; saw1 = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (c > 1) @(negedge clk);
      busy_cnt += int'(busy);
      if (conv_abcd == 4'h1) saw1 = 1;
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; digits = '0; start1 = 1'b0; digits1 = '0;
    repeat (3) @(negedge clk);
    total_n++; if (conv_reset !== 1'b1) $display("FAIL reset_conv_reset got %b want 1", conv_reset); else pass_n++;
    total_n++; if (conv_ready !== 1'b0) $display("FAIL reset_conv_ready got %b want 0", conv_ready); else pass_n++;
    total_n++; if (conv_abcd !== 4'h0) $display("FAIL reset_conv_abcd got %h want 0", conv_abcd); else pass_n++;
    total_n++; if ({busy, done, erro} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, erro}); else pass_n++;
    total_n++; if (erro_idx !== 3'd0) $display("FAIL reset_erro_idx got %0d want 0", erro_idx); else pass_n++;
    total_n++; if (codes !== 20'h0) $display("FAIL reset_codes got %h want 0", codes); else pass_n++;
    reset = 1'b0;
    @(negedge clk);
    total_n++; if ({busy, done} !== 2'b00) $display("FAIL idle_flags got %b want 00", {busy, done}); else pass_n++;
  endtask

  task automatic test_normal;
    logic [15:0] w;
    logic [3:0]  ea;
    w = 16'h9751;
    go(w);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      ea = c <= 8 ? w[4*((c-1)/2) +: 4] : 4'h0;
      total_n++;
      if ({busy, done, conv_ready, conv_abcd} !== {c <= 9, c == 9, c <= 8, ea})
        $display("FAIL normal_cycle%0d got busy=%b done=%b ready=%b abcd=%h want %b %b %b %h",
                 c, busy, done, conv_ready, conv_abcd, c <= 9, c == 9, c <= 8, ea);
      else pass_n++;
      if (c == 9) begin
        total_n++; if (codes !== 20'b00001_00111_11111_10000) $display("FAIL normal_codes got %b want 00001001111111110000", codes); else pass_n++;
        total_n++; if (erro !== 1'b0) $display("FAIL normal_erro got %b want 0", erro); else pass_n++;
      end
    end
  endtask

  task automatic test_invalid;
    int da, bc;
    bit s1;
    go(16'h1A23);
    watch(30, da, bc, s1);
    total_n++; if (da != 7) $display("FAIL invalid_done_cycle got %0d want 7", da); else pass_n++;
    total_n++; if (bc != 7) $display("FAIL invalid_busy_cycles got %0d want 7", bc); else pass_n++;
    total_n++; if (erro !== 1'b1) $display("FAIL invalid_erro got %b want 1", erro); else pass_n++;
    total_n++; if (erro_idx !== 3'd2) $display("FAIL invalid_erro_idx got %0d want 2", erro_idx); else pass_n++;
    total_n++; if (codes !== 20'b00000_00000_11000_11100) $display("FAIL invalid_codes got %b want 00000000001100011100", codes); else pass_n++;
    total_n++; if (s1) $display("FAIL invalid_abcd_1 got seen want never"); else pass_n++;
  endtask

  task automatic test_sticky;
    int da, bc;
    bit s1;
    repeat (3) @(negedge clk);
    total_n++; if ({erro, erro_idx} !== {1'b1, 3'd2}) $display("FAIL sticky_hold got %b/%0d want 1/2", erro, erro_idx); else pass_n++;
    go(16'h0000);
    total_n++; if (erro !== 1'b0) $display("FAIL sticky_clear got %b want 0", erro); else pass_n++;
    watch(30, da, bc, s1);
    total_n++; if (da != 9) $display("FAIL sticky_done_cycle got %0d want 9", da); else pass_n++;
    total_n++; if ({erro, codes} !== 21'h0) $display("FAIL sticky_result got erro=%b codes=%h want 0 00000", erro, codes); else pass_n++;
  endtask

  task automatic test_start_busy;
    int da, bc, ei, dc;
    bit s1, e;
    logic [39:0] ec;
    go(16'h9751);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) begin start = 1'b1; digits = 16'h2222; end
      if (c == 4) start = 1'b0;
      if (c == 9) begin start = 1'b1; digits = 16'h3333; end
      if (c == 10) begin
        digits = 16'h0246;
        total_n++;
        if ({busy, codes} !== {1'b0, 20'b00001_00111_11111_10000})
          $display("FAIL busy_start_ignored got busy=%b codes=%b want 0 00001001111111110000", busy, codes);
        else pass_n++;
      end
      if (c == 11) begin
        start = 1'b0;
        total_n++;
        if ({busy, codes} !== {1'b1, 20'h0}) $display("FAIL busy_start_accept got busy=%b codes=%h want 1 00000", busy, codes);
        else pass_n++;
      end
    end
    model(32'h0246, 4, ec, e, ei, dc);
    watch(30, da, bc, s1);
    total_n++; if (da != 9) $display("FAIL busy_next_done got %0d want 9", da); else pass_n++;
    total_n++; if (codes !== ec[19:0]) $display("FAIL busy_next_codes got %h want %h", codes, ec[19:0]); else pass_n++;
  endtask

  task automatic test_reset_mid;
    int da, bc, ei, dc;
    bit s1, e;
    logic [39:0] ec;
    go(16'h9751);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 4) begin
        reset = 1'b1;
        #1;
        total_n++;
        if ({conv_reset, conv_ready, conv_abcd, done} !== 7'b1000000)
          $display("FAIL rstmid_conv got reset=%b ready=%b abcd=%h done=%b want 1 0 0 0", conv_reset, conv_ready, conv_abcd, done);
        else pass_n++;
      end
      if (c == 5) begin
        reset = 1'b0;
        total_n++;
        if ({busy, done, erro, erro_idx, codes} !== 26'h0)
          $display("FAIL rstmid_outputs got busy=%b done=%b erro=%b idx=%0d codes=%h want all 0", busy, done, erro, erro_idx, codes);
        else pass_n++;
        start = 1'b1; digits = 16'h8642;
      end
    end
    @(negedge clk); start = 1'b0;
    model(32'h8642, 4, ec, e, ei, dc);
    watch(30, da, bc, s1);
    total_n++; if (da != 9) $display("FAIL rstmid_done got %0d want 9", da); else pass_n++;
    total_n++; if (codes !== ec[19:0]) $display("FAIL rstmid_codes got %h want %h", codes, ec[19:0]); else pass_n++;
  endtask

  task automatic test_back_to_back;
    int da, bc, ei, dc;
    bit s1, e;
    logic [39:0] ec;
    go(16'h1234);
    watch(30, da, bc, s1);
    go(16'h5678);
    total_n++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); else pass_n++;
    model(32'h5678, 4, ec, e, ei, dc);
    watch(30, da, bc, s1);
    total_n++; if (da != 9 || codes !== ec[19:0]) $display("FAIL b2b_second got done=%0d codes=%h want 9 %h", da, codes, ec[19:0]); else pass_n++;
  endtask

  task automatic test_random;
    int da, bc, ei, dc;
    bit s1, e;
    logic [39:0] ec;
    logic [15:0] d;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++)
        d[4*i +: 4] = 4'($urandom_range(0, 7) == 0 ? $urandom_range(10, 15) : $urandom_range(0, 9));
      model({16'h0, d}, 4, ec, e, ei, dc);
      go(d);
      watch(30, da, bc, s1);
      total_n++;
      if (da != dc || bc != dc || erro !== e || codes !== ec[19:0] || (e && erro_idx !== 3'(ei)))
        $display("FAIL random_%0d digits=%h got done=%0d busy=%0d erro=%b idx=%0d codes=%h want %0d %0d %b %0d %h",
                 r, d, da, bc, erro, erro_idx, codes, dc, dc, e, ei, ec[19:0]);
      else pass_n++;
    end
  endtask

  task automatic test_min_width;
    int da;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); start1 = 1'b1; digits1 = k == 0 ? 4'h9 : 4'hC;
      @(negedge clk); start1 = 1'b0;
      da = -1;
      for (int c = 1; c <= 10; c++) begin
        if (c > 1) @(negedge clk);
        if (done1) begin
          da = c;
          break;
        end
      end
      total_n++; if (da != 3) $display("FAIL min%0d_done got %0d want 3", k, da); else pass_n++;
      total_n++;
      if ({erro1, erro_idx1, codes1} !== (k == 0 ? {1'b0, 3'd0, 5'b00001} : 9'h100))
        $display("FAIL min%0d_result got erro=%b idx=%0d codes=%b", k, erro1, erro_idx1, codes1);
      else pass_n++;
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_invalid;
    test_sticky;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_min_width;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/numero_sequencer.md
# numero_sequencer

Sequencing controller for the single-digit BCD-to-5-bit `Numero` converter. It accepts a packed multi-digit BCD word and drives the shared combinational converter one digit per slot through its `ready`/`reset`/invalid interface. It collects each 5-bit code into an output word and aborts on the first digit above 9. The converter sits beside it in the parent, wired to the `conv_*` ports.

## Interface
- `N_DIGITS`, default 4: number of BCD digits per request, valid range 1..8.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request pulse; accepted only in IDLE.
- `digits`  in  4*N_DIGITS: packed BCD; digit i = `digits[4i+3:4i]`, bit 3 = A (MSB), bit 0 = D.
- `busy`  out  1: high from the cycle after an accepted `start` until return to IDLE.
- `done`  out  1: one-cycle pulse at the end of every request, whether it completes or errors.
- `erro`  out  1: sticky invalid-digit flag; cleared by an accepted `start` or by `reset`.
- `erro_idx`  out  3: index of the offending digit; valid while `erro`=1.
- `codes`  out  5*N_DIGITS: slice i = `codes[5i+4:5i]` = {d5,d4,d3,d2,d1} of digit i.
- `conv_abcd`  out  4: digit presented to the converter as {A,B,C,D}.
- `conv_ready`  out  1: converter `ready`.
- `conv_reset`  out  1: converter `reset`.
- `conv_d`  in  5: converter outputs {d5,d4,d3,d2,d1}.
- `conv_invalid`  in  1: converter `Ativa_vermelho`.

## Operation
- **States:** IDLE, DRIVE, SAMPLE, DONE, ERR.
- **IDLE:**
  - If `start`=1: register `digits` into an internal copy, clear `codes`, `erro` and `erro_idx`, set idx=0, and go to DRIVE.
  - Otherwise stay in IDLE.
- **DRIVE:** `conv_abcd` = digit[idx], `conv_ready`=1, `conv_reset`=0. Always go to SAMPLE.
- **SAMPLE:** keep the same converter drive.
  - If `conv_invalid`=1: set `erro`=1, set `erro_idx`=idx, leave slice idx unwritten, and go to ERR.
  - Else write `conv_d` into slice idx.
    - If idx=N_DIGITS-1, go to DONE.
    - Otherwise increment idx and go to DRIVE.
- **DONE and ERR:** `done`=1 for that cycle, then go to IDLE.
- **Converter drive outside DRIVE/SAMPLE:** `conv_abcd`=0, `conv_ready`=0, `conv_reset`=1.
- **`start` outside IDLE** (including in DONE/ERR): ignored. `digits` is sampled only at acceptance.
- **After a request:** `codes` holds its value until the next accepted `start`. After an error, slices at and above `erro_idx` read 0.
- **idx width:** 3 bits. Wrap-around never occurs because the terminal check is at N_DIGITS-1.

## Timing
- **Reset:** synchronous.
  - Next state is IDLE.
  - `busy`, `done` and `erro` are 0; `erro_idx`=0; `codes`=0.
  - `conv_reset`=1 in the reset cycle itself (combinational from `reset`); `conv_abcd`=0; `conv_ready`=0.
  - Reset mid-request aborts with no `done` pulse.
- **Latency:** with `start` accepted at edge 0, digit i is driven in cycle 2i+1 and sampled at the end of cycle 2i+2. `done` is high in cycle 2·N_DIGITS+1 (cycle 9 for N_DIGITS=4).
- **Error latency:** an invalid digit i gives `done`+`erro` in cycle 2i+3.
- **Registered outputs:** `busy`, `done`, `erro`, `erro_idx`, `codes`.
- **Combinational outputs:** `conv_*`, decoded from state, idx and `reset`.
- **Back-to-back:** the earliest next `start` is accepted in the IDLE cycle after `done`, giving a minimum period of 2·N_DIGITS+2 cycles.
- **Converter timing:** each digit is held for two cycles. The converter settles in DRIVE and is sampled in SAMPLE, so no converter output is used in the same cycle its input changes.

## Structure
- **Shared package `numero_pkg`:**
  - State enum.
  - `BCD_W`=4, `CODE_W`=5, `BCD_MAX`=9, `IDX_W`=3.
  - Default `N_DIGITS`=4.
- **Sub-module `digit_select`:** combinational mux of the registered digit copy by idx, sized by `N_DIGITS`.
- **Converter:** not instantiated here. The parent connects it to the `conv_*` ports.

## Test plan
Concrete code values below assume the real converter equations.

- **Normal request:** N_DIGITS=4, `digits`=16'h9751, `start` pulse.
  - `busy` high cycles 1–9; `done` in cycle 9; `erro`=0.
  - `codes` = 20'b00001_00111_11111_10000.
- **Invalid digit:** `digits`=16'h1A23.
  - `done`+`erro` in cycle 7; `erro_idx`=2.
  - `codes` = 20'b00000_00000_11000_11100; `conv_abcd` never carries 4'h1.
- **`start` while busy:** `start` re-pulsed in cycles 3 and 9 with different `digits`.
  - Ignored; the first request's `codes` are unchanged.
  - A `start` in cycle 10 is accepted.
- **Reset mid-request:** `reset` in cycle 4.
  - All outputs 0 in cycle 5; no `done`; `conv_reset`=1 in cycle 4.
  - A new `start` in cycle 5 completes normally.
- **Sticky error cleared by clean request:** run the error request, then `digits`=16'h0000.
  - `erro` stays 1 until the accepted `start`, then reads 0.
  - `codes` = 20'h00000; `done` in cycle 9 of the new request.
- **Minimal width:** N_DIGITS=1, `digits`=4'h9.
  - `done` in cycle 3; `codes` = 5'b00001.
